// File: rtl/evo_xb_pin_in.sv
// Input conditioning for one GPIO port: 2-flop synchronizer, optional per-pin
// glitch filter, edge pulses and sticky interrupt flags, fanned out to MUX_WIDTH consumers.
module evo_xb_pin_in #(
    parameter int PORT_DWIDTH = 8,
    parameter int MUX_WIDTH   = 1,
    parameter int FILT_BITS   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PORT_DWIDTH-1:0]           pin_i,
    input  logic [PORT_DWIDTH-1:0]           filt_en_i,
    input  logic [FILT_BITS-1:0]             filt_len_i,
    input  logic [PORT_DWIDTH*MUX_WIDTH-1:0] sel_i,
    input  logic [PORT_DWIDTH-1:0]           rise_en_i,
    input  logic [PORT_DWIDTH-1:0]           fall_en_i,
    input  logic [PORT_DWIDTH-1:0]           irq_clr_i,
    output logic [PORT_DWIDTH*MUX_WIDTH-1:0] port_in_o,
    output logic [PORT_DWIDTH*MUX_WIDTH-1:0] port_rise_o,
    output logic [PORT_DWIDTH*MUX_WIDTH-1:0] port_fall_o,
    output logic [PORT_DWIDTH-1:0]           irq_flag_o,
    output logic                             irq_o
);

    localparam int W = PORT_DWIDTH;
    localparam logic [FILT_BITS-1:0] CNT_ZERO = {FILT_BITS{1'b0}};
    localparam logic [FILT_BITS-1:0] CNT_ONE  = FILT_BITS'(1'b1);
    localparam logic [1:0]           START_DONE = 2'd3;

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] st_q, st_d;
    logic [W-1:0] rq_q, rq_d;
    logic [W-1:0] fq_q, fq_d;
    logic [W-1:0] flg_q, flg_d;
    logic [W-1:0][FILT_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]   start_q, start_d;
    logic         start_done_s;

    // Next-state: startup counter, synchronizer, filter and edge/flag logic
    always_comb begin
        start_done_s = (start_q == START_DONE);
        if (start_done_s) begin
            start_d = start_q;
        end else begin
            start_d = start_q + 2'd1;
        end
        s1_d = pin_i;
        s2_d = s1_q;
        st_d = st_q;
        cnt_d = cnt_q;
        for (int p = 0; p < W; p++) begin
            // During startup st tracks s2 directly so a pin high through reset never looks like an edge
            if (!start_done_s || !filt_en_i[p]) begin
                st_d[p]  = s2_q[p];
                cnt_d[p] = CNT_ZERO;
            end else if (s2_q[p] == st_q[p]) begin
                cnt_d[p] = CNT_ZERO;
            end else if (cnt_q[p] >= filt_len_i) begin
                st_d[p]  = s2_q[p];
                cnt_d[p] = CNT_ZERO;
            end else begin
                cnt_d[p] = cnt_q[p] + CNT_ONE;
            end
        end
        if (start_done_s) begin
            rq_d = st_d & ~st_q;
            fq_d = ~st_d & st_q;
        end else begin
            rq_d = {W{1'b0}};
            fq_d = {W{1'b0}};
        end
        flg_d = (flg_q & ~irq_clr_i) | (rq_d & rise_en_i) | (fq_d & fall_en_i);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= {W{1'b0}};
            s2_q    <= {W{1'b0}};
            st_q    <= {W{1'b0}};
            rq_q    <= {W{1'b0}};
            fq_q    <= {W{1'b0}};
            flg_q   <= {W{1'b0}};
            cnt_q   <= {W{CNT_ZERO}};
            start_q <= 2'd0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            st_q    <= st_d;
            rq_q    <= rq_d;
            fq_q    <= fq_d;
            flg_q   <= flg_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    // Per-slot delivery; sel_i gates the registered values combinationally
    always_comb begin
        port_in_o   = {(W*MUX_WIDTH){1'b0}};
        port_rise_o = {(W*MUX_WIDTH){1'b0}};
        port_fall_o = {(W*MUX_WIDTH){1'b0}};
        for (int m = 0; m < MUX_WIDTH; m++) begin
            port_in_o[m*W +: W]   = st_q & sel_i[m*W +: W];
            port_rise_o[m*W +: W] = rq_q & sel_i[m*W +: W];
            port_fall_o[m*W +: W] = fq_q & sel_i[m*W +: W];
        end
    end

    assign irq_flag_o = flg_q;
    assign irq_o      = |flg_q;

endmodule
